// File: rtl/wave_director_pkg.sv
// Shared types and defaults for the wave sequencer and the score-side speed logic.
package wave_director_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SPAWN  = 3'd1,
    ST_ACTIVE = 3'd2,
    ST_CLEAR  = 3'd3,
    ST_GAP    = 3'd4
  } state_e;

  localparam logic [23:0] SPEED_BASE = 24'd400000;
  localparam logic [23:0] SPEED_STEP = 24'd2000;
  localparam logic [23:0] SPEED_MIN  = 24'd100000;

  localparam logic [24:0] SPAWN_TIMEOUT_DEF = 25'd1000000;
  localparam logic [24:0] GAP_CYCLES_DEF    = 25'd25000000;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/wave_director_if.sv
// Game-state side <-> wave director signal bundle.
interface wave_director_if #(
  parameter int N_ENEMY = 4
);
  logic               pause;
  logic               game_start_on;
  logic               game_over_on;
  logic [15:0]        score;
  logic [N_ENEMY-1:0] enemy_active;
  logic [23:0]        wave_speed;
  logic [N_ENEMY-1:0] spawn_en;
  logic [7:0]         wave_num;
  logic               wave_clear;
  logic               intermission;

  modport master (
    output pause, game_start_on, game_over_on, score, enemy_active,
    input  wave_speed, spawn_en, wave_num, wave_clear, intermission
  );

  modport slave (
    input  pause, game_start_on, game_over_on, score, enemy_active,
    output wave_speed, spawn_en, wave_num, wave_clear, intermission
  );
endinterface

// File: rtl/wave_director_speed_calc.sv
// Score-to-speed divisor: saturating multiply-subtract, registered (1-cycle latency).
module wave_speed_calc
  import wave_director_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] score,
  output logic [23:0] wave_speed_q
);

  localparam logic [39:0] SPEED_RANGE = 40'(SPEED_BASE - SPEED_MIN);

  logic [39:0] prod;
  logic [23:0] wave_speed_d;

  always_comb begin
    prod = 40'(score) * 40'(SPEED_STEP);
    // prod < SPEED_RANGE < 2^24 on the subtract path, so truncation is exact
    if (prod >= SPEED_RANGE) begin
      wave_speed_d = SPEED_MIN;
    end else begin
      wave_speed_d = 24'(40'(SPEED_BASE) - prod);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wave_speed_q <= SPEED_BASE;
    end else begin
      wave_speed_q <= wave_speed_d;
    end
  end

endmodule

// File: rtl/wave_director.sv
// Wave sequencer: spawn gating, wave-clear detection, wave counting and intermission.
//   state     | meaning
//   IDLE      | title/game-over screen; nothing spawns
//   SPAWN     | spawn_en all ones until every enemy is up or timeout
//   ACTIVE    | wave in play; wait for all enemies inactive
//   CLEAR     | one-cycle wave_clear pulse, wave_num advanced
//   GAP       | intermission before next SPAWN
module wave_director
  import wave_director_pkg::*;
#(
  parameter int          N_ENEMY       = 4,
  parameter logic [24:0] SPAWN_TIMEOUT = SPAWN_TIMEOUT_DEF,
  parameter logic [24:0] GAP_CYCLES    = GAP_CYCLES_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  wave_director_if.slave bus
);

  localparam logic [24:0] SPAWN_LAST = SPAWN_TIMEOUT - 25'd1;
  localparam logic [24:0] GAP_LAST   = GAP_CYCLES - 25'd1;

  state_e             state_q, state_d;
  logic [24:0]        spawn_cnt_q, spawn_cnt_d;
  logic [24:0]        gap_cnt_q, gap_cnt_d;
  logic [7:0]         wave_num_q, wave_num_d;
  logic [N_ENEMY-1:0] spawn_en_q, spawn_en_d;
  logic               wave_clear_q, wave_clear_d;
  logic               intermission_q, intermission_d;
  logic [23:0]        wave_speed_q;
  logic               leave_game;

  wave_speed_calc u_speed (
    .clk          (clk),
    .rst_n        (rst_n),
    .score        (bus.score),
    .wave_speed_q (wave_speed_q)
  );

  assign leave_game = bus.game_over_on || bus.game_start_on;

  always_comb begin
    state_d     = state_q;
    spawn_cnt_d = spawn_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    wave_num_d  = wave_num_q;

    // Screen change beats pause and every other transition
    if ((state_q != ST_IDLE) && leave_game) begin
      state_d     = ST_IDLE;
      spawn_cnt_d = '0;
      gap_cnt_d   = '0;
    end else if (!bus.pause) begin
      unique case (state_q)
        ST_IDLE: begin
          if (!leave_game) begin
            state_d    = ST_SPAWN;
            wave_num_d = '0;
          end
        end
        ST_SPAWN: begin
          if ((&bus.enemy_active) || (spawn_cnt_q == SPAWN_LAST)) begin
            state_d     = ST_ACTIVE;
            spawn_cnt_d = '0;
          end else begin
            spawn_cnt_d = spawn_cnt_q + 25'd1;
          end
        end
        ST_ACTIVE: begin
          if (bus.enemy_active == '0) begin
            state_d    = ST_CLEAR;
            wave_num_d = sat_inc8(wave_num_q);
          end
        end
        ST_CLEAR: begin
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_cnt_q == GAP_LAST) begin
            state_d   = ST_SPAWN;
            gap_cnt_d = '0;
          end else begin
            gap_cnt_d = gap_cnt_q + 25'd1;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Outputs follow the next state so they line up with the state register
    spawn_en_d     = (state_d == ST_SPAWN) ? '1 : '0;
    intermission_d = (state_d == ST_GAP);
    wave_clear_d   = (state_d == ST_CLEAR) && (state_q != ST_CLEAR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      spawn_cnt_q    <= '0;
      gap_cnt_q      <= '0;
      wave_num_q     <= '0;
      spawn_en_q     <= '0;
      wave_clear_q   <= 1'b0;
      intermission_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      spawn_cnt_q    <= spawn_cnt_d;
      gap_cnt_q      <= gap_cnt_d;
      wave_num_q     <= wave_num_d;
      spawn_en_q     <= spawn_en_d;
      wave_clear_q   <= wave_clear_d;
      intermission_q <= intermission_d;
    end
  end

  assign bus.wave_speed   = wave_speed_q;
  assign bus.spawn_en     = spawn_en_q;
  assign bus.wave_num     = wave_num_q;
  assign bus.wave_clear   = wave_clear_q;
  assign bus.intermission = intermission_q;

endmodule

// File: tb/tb_wave_director.sv
// Directed bench for wave_director with a small expected-value scoreboard.
module tb_wave_director;
  import wave_director_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  wave_director_if #(.N_ENEMY(4)) bus ();

  wave_director #(
    .N_ENEMY       (4),
    .SPAWN_TIMEOUT (25'd8),
    .GAP_CYCLES    (25'd4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic sb_check(input logic [31:0] obs);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", obs);
    end else begin
      check(tag_q.pop_front(), obs, exp_q.pop_front());
    end
  endtask

  function automatic logic [31:0] speed_model(input int s);
    longint prod;
    prod = longint'(s) * 2000;
    if (prod >= 300000) return 32'd100000;
    return 32'(400000 - prod);
  endfunction

  task automatic wait_spawn();
    int g;
    g = 0;
    while (bus.spawn_en !== 4'hF && g < 50) begin
      tick();
      g++;
    end
    check("wait_spawn", bus.spawn_en, 4'hF);
  endtask

  initial begin
    int cnt;
    int k;
    int guard;
    int scores[7];
    logic [31:0] prev_speed;

    n_checks = 0;
    n_fail   = 0;
    scores   = '{0, 100, 150, 65535, 1, 149, 50};

    rst_n             = 1'b0;
    bus.pause         = 1'b0;
    bus.game_start_on = 1'b1;
    bus.game_over_on  = 1'b0;
    bus.score         = 16'd0;
    bus.enemy_active  = 4'b0000;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    check("rst_wave_speed", bus.wave_speed, 400000);
    check("rst_spawn_en", bus.spawn_en, 0);
    check("rst_wave_num", bus.wave_num, 0);
    check("rst_wave_clear", bus.wave_clear, 0);
    check("rst_intermission", bus.intermission, 0);

    // Speed mapping, one clock of latency
    foreach (scores[i]) begin
      prev_speed = speed_model(i == 0 ? 0 : scores[i-1]);
      bus.score = 16'(scores[i]);
      sb_push("speed", speed_model(scores[i]));
      #1;
      check("speed_latency", bus.wave_speed, prev_speed);
      tick();
      sb_check(bus.wave_speed);
    end
    bus.score = 16'd0;
    tick();

    // Full wave
    bus.game_start_on = 1'b0;
    tick();
    check("wave1_spawn_en", bus.spawn_en, 4'hF);
    check("wave1_intermission", bus.intermission, 0);
    bus.enemy_active = 4'b1111;
    tick();
    check("wave1_active_spawn_en", bus.spawn_en, 0);
    bus.enemy_active = 4'b0111;
    tick();
    check("wave1_no_clear_0111", bus.wave_clear, 0);
    bus.enemy_active = 4'b0011;
    tick();
    check("wave1_no_clear_0011", bus.wave_clear, 0);
    bus.enemy_active = 4'b0001;
    tick();
    check("wave1_no_clear_0001", bus.wave_clear, 0);
    bus.enemy_active = 4'b0000;
    sb_push("wave1_num", 1);
    tick();
    check("wave1_clear", bus.wave_clear, 1);
    sb_check(bus.wave_num);
    tick();
    check("wave1_clear_single", bus.wave_clear, 0);
    cnt = 0;
    while (bus.intermission === 1'b1 && cnt < 20) begin
      cnt++;
      tick();
    end
    check("wave1_gap_len", cnt, 4);
    check("wave1_respawn", bus.spawn_en, 4'hF);

    // Spawn timeout with partial spawn
    bus.enemy_active = 4'b0011;
    cnt = 0;
    while (bus.spawn_en === 4'hF && cnt < 20) begin
      cnt++;
      tick();
    end
    check("timeout_spawn_len", cnt, 8);
    check("timeout_no_clear", bus.wave_clear, 0);
    bus.enemy_active = 4'b0000;
    sb_push("wave2_num", 2);
    tick();
    check("wave2_clear", bus.wave_clear, 1);
    sb_check(bus.wave_num);

    // Pause defers clear, stretches gap
    wait_spawn();
    bus.enemy_active = 4'b1111;
    tick();
    check("pause_active", bus.spawn_en, 0);
    bus.enemy_active = 4'b0000;
    bus.pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("pause_no_clear", bus.wave_clear, 0);
    end
    check("pause_num_held", bus.wave_num, 2);
    bus.pause = 1'b0;
    sb_push("wave3_num", 3);
    tick();
    check("pause_release_clear", bus.wave_clear, 1);
    sb_check(bus.wave_num);
    tick();
    cnt = 0;
    while (bus.intermission === 1'b1 && cnt < 30) begin
      cnt++;
      if (cnt == 1) bus.pause = 1'b1;
      if (cnt == 4) bus.pause = 1'b0;
      tick();
    end
    check("pause_gap_len", cnt, 7);
    check("pause_gap_respawn", bus.spawn_en, 4'hF);

    // Game over from ACTIVE
    bus.enemy_active = 4'b1111;
    tick();
    bus.game_over_on = 1'b1;
    tick();
    check("over_state", dut.state_q, ST_IDLE);
    check("over_spawn_en", bus.spawn_en, 0);
    check("over_wave_num", bus.wave_num, 3);
    check("over_intermission", bus.intermission, 0);
    bus.game_over_on  = 1'b0;
    bus.game_start_on = 1'b1;
    tick();
    check("title_wave_num", bus.wave_num, 3);
    bus.game_start_on = 1'b0;
    tick();
    check("restart_wave_num", bus.wave_num, 0);
    check("restart_spawn_en", bus.spawn_en, 4'hF);

    // Saturation over 256 clears
    bus.enemy_active = 4'b0000;
    bus.score        = 16'd65535;
    k     = 0;
    guard = 0;
    while (k < 256 && guard < 6000) begin
      tick();
      guard++;
      if (bus.wave_clear === 1'b1) begin
        k++;
        sb_push("sat_num", (k > 255) ? 255 : k);
        sb_check(bus.wave_num);
      end
    end
    check("sat_clear_count", k, 256);
    check("sat_final", bus.wave_num, 255);
    check("sat_speed", bus.wave_speed, 100000);

    // Async reset mid-GAP
    tick();
    check("pre_reset_gap", bus.intermission, 1);
    rst_n = 1'b0;
    #1;
    check("areset_wave_speed", bus.wave_speed, 400000);
    check("areset_spawn_en", bus.spawn_en, 0);
    check("areset_wave_num", bus.wave_num, 0);
    check("areset_wave_clear", bus.wave_clear, 0);
    check("areset_intermission", bus.intermission, 0);
    check("areset_state", dut.state_q, ST_IDLE);
    check("sb_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
